// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single UART transmitter from a player and a host byte source.
// Latency: request sampled in IDLE at edge N -> tx_ctrl/ack registered high during cycle N+1.
// Backpressure: grants only while transmit_ready=1 in IDLE; requesters hold req until their ack.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 50000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_p,
    input  logic [7:0] data_p,
    input  logic       req_h,
    input  logic [7:0] data_h,
    input  logic       transmit_ready,
    input  logic       err_clr,
    output logic       ack_p,
    output logic       ack_h,
    output logic       tx_ctrl,
    output logic [7:0] tx_byte,
    output logic       last_src,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] tx_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             rr, rr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             grant_h;
    logic             ack_p_nxt, ack_h_nxt, tx_ctrl_nxt;
    logic [7:0]       tx_byte_nxt;
    logic             last_src_nxt;
    logic             busy_nxt;
    logic             timeout_err_nxt;
    logic [7:0]       tx_count_nxt;

    // Host wins when it is the only requester, or when both ask and rr points at it.
    assign grant_h = req_h & (~req_p | rr);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_nxt       = state;
        rr_nxt          = rr;
        cnt_nxt         = cnt;
        ack_p_nxt       = 1'b0;
        ack_h_nxt       = 1'b0;
        tx_ctrl_nxt     = 1'b0;
        tx_byte_nxt     = tx_byte;
        last_src_nxt    = last_src;
        tx_count_nxt    = tx_count;
        // A timeout set below overrides a simultaneous clear.
        timeout_err_nxt = timeout_err & ~err_clr;

        case (state)
            IDLE: begin
                if (transmit_ready && (req_p || req_h)) begin
                    state_nxt    = START;
                    ack_p_nxt    = ~grant_h;
                    ack_h_nxt    = grant_h;
                    tx_ctrl_nxt  = 1'b1;
                    tx_byte_nxt  = grant_h ? data_h : data_p;
                    last_src_nxt = grant_h;
                    rr_nxt       = ~grant_h;
                    cnt_nxt      = '0;
                end
            end
            START: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Exit condition is checked before the timeout so it wins a tie.
                if (!transmit_ready) begin
                    state_nxt = WAIT_DONE;
                    cnt_nxt   = cnt + 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt       = IDLE;
                    timeout_err_nxt = 1'b1;
                    cnt_nxt         = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (transmit_ready) begin
                    state_nxt    = IDLE;
                    tx_count_nxt = tx_count + 8'd1;
                    cnt_nxt      = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt       = IDLE;
                    timeout_err_nxt = 1'b1;
                    cnt_nxt         = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Registered outputs, arbitration pointer and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr          <= 1'b0;
            cnt         <= '0;
            ack_p       <= 1'b0;
            ack_h       <= 1'b0;
            tx_ctrl     <= 1'b0;
            tx_byte     <= 8'h00;
            last_src    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tx_count    <= 8'h00;
        end else begin
            rr          <= rr_nxt;
            cnt         <= cnt_nxt;
            ack_p       <= ack_p_nxt;
            ack_h       <= ack_h_nxt;
            tx_ctrl     <= tx_ctrl_nxt;
            tx_byte     <= tx_byte_nxt;
            last_src    <= last_src_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
            tx_count    <= tx_count_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected grants popped on each start strobe.
// Latency: stimulus driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
// Backpressure: the transmitter is modelled procedurally by dropping/raising transmit_ready.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_p = 1'b0;
    logic [7:0] data_p = 8'h00;
    logic       req_h = 1'b0;
    logic [7:0] data_h = 8'h00;
    logic       transmit_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic       ack_p, ack_h, tx_ctrl;
    logic [7:0] tx_byte;
    logic       last_src, busy, timeout_err;
    logic [7:0] tx_count;

    typedef struct packed {
        logic       src;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_count = 8'h00;

    uart_tx_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_p          (req_p),
        .data_p         (data_p),
        .req_h          (req_h),
        .data_h         (data_h),
        .transmit_ready (transmit_ready),
        .err_clr        (err_clr),
        .ack_p          (ack_p),
        .ack_h          (ack_h),
        .tx_ctrl        (tx_ctrl),
        .tx_byte        (tx_byte),
        .last_src       (last_src),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .tx_count       (tx_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [7:0] dat);
        exp_t e;
        e.src = src;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!tx_ctrl && n < 40);
        chk("start_seen", tx_ctrl, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 40);
        chk("idle_seen", busy, 0);
    endtask

    // Transmitter busy for n cycles starting in the START cycle.
    task automatic uart_shift(input int n);
        transmit_ready = 1'b0;
        repeat (n) tick();
        transmit_ready = 1'b1;
    endtask

    task automatic chk_zero_outs();
        chk("rst_tx_ctrl", tx_ctrl, 0);
        chk("rst_ack_p", ack_p, 0);
        chk("rst_ack_h", ack_h, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_last_src", last_src, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_tx_count", tx_count, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 8'h00;
    endtask

    // Scoreboard: every start strobe or ack must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst && (tx_ctrl || ack_p || ack_h)) begin
            chk("sb_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_tx_ctrl", tx_ctrl, 1);
                chk("sb_tx_byte", tx_byte, e.dat);
                chk("sb_last_src", last_src, e.src);
                chk("sb_ack_p", ack_p, !e.src);
                chk("sb_ack_h", ack_h, e.src);
            end
        end
    end

    initial begin
        int last_cyc;

        // Reset state
        tick();
        rst = 1'b1;
        tick();
        chk_zero_outs();
        rst = 1'b0;

        // Single player request, one-cycle grant latency
        req_p = 1'b1;
        data_p = 8'h41;
        push(1'b0, 8'h41);
        tick();
        chk("single_latency", tx_ctrl, 1);
        chk("single_ack_p", ack_p, 1);
        req_p = 1'b0;
        uart_shift(3);
        wait_idle();
        exp_count++;
        chk("single_count", tx_count, exp_count);

        // Contention from reset: P,H,P,H with minimum spacing between strobes
        do_reset();
        req_p = 1'b1;
        req_h = 1'b1;
        data_p = 8'h33;
        data_h = 8'h5A;
        push(1'b0, 8'h33);
        push(1'b1, 8'h5A);
        push(1'b0, 8'h33);
        push(1'b1, 8'h5A);
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_start();
            if (k > 0) chk("rr_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            if (k == 3) begin
                req_p = 1'b0;
                req_h = 1'b0;
            end
            uart_shift(2);
        end
        wait_idle();
        exp_count += 8'd4;
        chk("rr_count", tx_count, exp_count);

        // Blocked transmitter holds off the grant
        transmit_ready = 1'b0;
        req_h = 1'b1;
        data_h = 8'hC3;
        push(1'b1, 8'hC3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("blk_no_start", tx_ctrl | ack_h, 0);
        end
        transmit_ready = 1'b1;
        tick();
        chk("blk_start", tx_ctrl, 1);
        req_h = 1'b0;
        uart_shift(3);
        wait_idle();
        exp_count++;
        chk("blk_count", tx_count, exp_count);

        // Timeout: transmitter never goes busy
        req_p = 1'b1;
        data_p = 8'h77;
        push(1'b0, 8'h77);
        wait_start();
        req_p = 1'b0;
        repeat (8) tick();
        chk("to_busy_last", busy, 1);
        tick();
        chk("to_idle", busy, 0);
        chk("to_err_set", timeout_err, 1);
        chk("to_count_kept", tx_count, exp_count);
        tick();
        chk("to_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr", timeout_err, 0);

        // Timeout coinciding with err_clr: set wins
        req_p = 1'b1;
        data_p = 8'h78;
        push(1'b0, 8'h78);
        wait_start();
        req_p = 1'b0;
        repeat (8) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_set_wins", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr2", timeout_err, 0);

        // Completion on the last allowed cycle beats the timeout
        req_p = 1'b1;
        data_p = 8'h79;
        push(1'b0, 8'h79);
        wait_start();
        req_p = 1'b0;
        uart_shift(8);
        wait_idle();
        exp_count++;
        chk("tie_count", tx_count, exp_count);
        chk("tie_no_err", timeout_err, 0);

        // Reset while in WAIT_DONE with a host request pending
        req_h = 1'b1;
        data_h = 8'h99;
        push(1'b1, 8'h99);
        wait_start();
        transmit_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_zero_outs();
        tick();
        chk("rst_no_ack_h", ack_h | tx_ctrl, 0);
        req_h = 1'b0;
        transmit_ready = 1'b1;
        rst = 1'b0;
        exp_count = 8'h00;

        // Wrap: 256 completed transfers return the count to zero
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = 8'(i * 7 + 3);
            if (i[0]) begin
                req_h = 1'b1;
                data_h = d;
            end else begin
                req_p = 1'b1;
                data_p = d;
            end
            push(i[0], d);
            wait_start();
            req_p = 1'b0;
            req_h = 1'b0;
            uart_shift(2);
            wait_idle();
            exp_count++;
            if (i == 254) chk("wrap_255", tx_count, 8'hFF);
        end
        chk("wrap_zero", tx_count, exp_count);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
